// File: rtl/psg_pkg.sv
// Shared types and byte-encoding helpers for the PSG bus writer.
// Channel 3 is the noise channel; volume writes set the type bit of the latch byte.
package psg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_STROBE   = 3'd2,
        ST_WAIT_RDY = 3'd3,
        ST_RELEASE  = 3'd4,
        ST_GAP      = 3'd5
    } psg_state_e;

    typedef logic [1:0] psg_channel_t;

    localparam int LATCH_BIT = 7;
    localparam int CH_HI_BIT = 6;
    localparam int CH_LO_BIT = 5;
    localparam int VOL_BIT   = 4;
    localparam int CMD_W     = 13;

    localparam psg_channel_t NOISE_CH = 2'd3;

    typedef struct packed {
        psg_channel_t channel;
        logic         is_vol;
        logic [9:0]   value;
    } psg_cmd_t;

    function automatic logic has_data_byte(input psg_cmd_t c);
        return !c.is_vol && (c.channel != NOISE_CH);
    endfunction

    function automatic logic [7:0] latch_byte(input psg_cmd_t c);
        logic [7:0] b;
        b                      = '0;
        b[LATCH_BIT]           = 1'b1;
        b[CH_HI_BIT:CH_LO_BIT] = c.channel;
        b[VOL_BIT]             = c.is_vol;
        if (!c.is_vol && (c.channel == NOISE_CH)) begin
            b[3:0] = {1'b0, c.value[2:0]};
        end else begin
            b[3:0] = c.value[3:0];
        end
        return b;
    endfunction

    function automatic logic [7:0] data_byte(input psg_cmd_t c);
        return {2'b00, c.value[9:4]};
    endfunction

endpackage

// File: rtl/psg_cmd_fifo.sv
// Small synchronous command FIFO; simultaneous push and pop are both honoured.
module psg_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 13
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/psg_bus_writer.sv
// Drains queued PSG commands onto the chip bus as one or two strobed bytes,
// waiting for READY after each strobe and giving up after a bounded wait.
module psg_bus_writer
    import psg_pkg::*;
#(
    parameter int STROBE_CYC  = 16,
    parameter int TIMEOUT_CYC = 255,
    parameter int GAP_CYC     = 2
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_channel,
    input  logic       cmd_is_vol,
    input  logic [9:0] cmd_value,
    input  logic       READY,
    output logic       nCE,
    output logic       nWE,
    output logic [7:0] D,
    output logic       busy,
    output logic       err_timeout,
    input  logic       err_clr
);

    localparam int MAX_ST = (STROBE_CYC > GAP_CYC) ? STROBE_CYC : GAP_CYC;
    localparam int MAX_CYC = (TIMEOUT_CYC > MAX_ST) ? TIMEOUT_CYC : MAX_ST;
    localparam int CNT_W = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] STROBE_LAST  = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYC - 1);

    psg_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       byte_q, byte_d;
    logic [7:0]       second_q, second_d;
    logic             pend_q, pend_d;
    logic             err_q, err_d;
    logic             nce_q, nce_d;
    logic             nwe_q, nwe_d;
    logic             err_set;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CMD_W-1:0] fifo_dout;
    psg_cmd_t         head;
    psg_cmd_t         cmd_in;

    assign cmd_in = '{channel: cmd_channel, is_vol: cmd_is_vol, value: cmd_value};
    assign head   = psg_cmd_t'(fifo_dout);

    psg_cmd_fifo #(
        .DEPTH (4),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_ni  (nRST),
        .push_i  (cmd_valid),
        .data_i  (cmd_in),
        .pop_i   (fifo_pop),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        byte_d   = byte_q;
        second_d = second_q;
        pend_d   = pend_q;
        err_set  = 1'b0;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    byte_d   = latch_byte(head);
                    second_d = data_byte(head);
                    pend_d   = has_data_byte(head);
                    cnt_d    = '0;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d   = '0;
                state_d = ST_STROBE;
            end
            ST_STROBE: begin
                if (cnt_q == STROBE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_RDY;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // READY is checked before the timeout so a last-moment READY still counts.
            ST_WAIT_RDY: begin
                if (READY) begin
                    cnt_d   = '0;
                    state_d = ST_RELEASE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    err_set = 1'b1;
                    pend_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                cnt_d   = '0;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (pend_q) begin
                        byte_d  = second_q;
                        pend_d  = 1'b0;
                        state_d = ST_SETUP;
                    end else begin
                        byte_d  = '0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                byte_d  = '0;
                pend_d  = 1'b0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        // Strobes are registered from the next state so the chip sees clean edges.
        nce_d = !(state_d inside {ST_SETUP, ST_STROBE, ST_WAIT_RDY, ST_RELEASE});
        nwe_d = !(state_d inside {ST_STROBE, ST_WAIT_RDY});
        err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            byte_q   <= '0;
            second_q <= '0;
            pend_q   <= 1'b0;
            err_q    <= 1'b0;
            nce_q    <= 1'b1;
            nwe_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            byte_q   <= byte_d;
            second_q <= second_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
            nce_q    <= nce_d;
            nwe_q    <= nwe_d;
        end
    end

    assign nCE         = nce_q;
    assign nWE         = nwe_q;
    assign D           = byte_q;
    assign err_timeout = err_q;
    assign busy        = (state_q != ST_IDLE) || !fifo_empty;
    assign cmd_ready   = !fifo_full;

endmodule

// File: tb/tb_psg_bus_writer.sv
// Bench for psg_bus_writer: directed vector table, backpressure, randomized
// batches against a byte-level model, a mid-strobe reset, and a bus protocol monitor.
module tb_psg_bus_writer;

    localparam int STROBE  = 16;
    localparam int TIMEOUT = 255;
    localparam int GAP     = 2;
    localparam int NEVER   = 100000;

    logic       CLK;
    logic       nRST;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_channel;
    logic       cmd_is_vol;
    logic [9:0] cmd_value;
    logic       READY;
    logic       nCE;
    logic       nWE;
    logic [7:0] D;
    logic       busy;
    logic       err_timeout;
    logic       err_clr;

    typedef struct {
        logic [1:0] ch;
        logic       isVol;
        logic [9:0] value;
    } cmd_t;

    typedef struct {
        logic [7:0] d;
        int         low;
    } rec_t;

    typedef struct {
        cmd_t       cmd;
        int         readyDelay;
        logic       clrAtSet;
        int         nBytes;
        logic [7:0] b0;
        logic [7:0] b1;
        int         expLow;
        logic       expErr;
    } vec_t;

    int   vectors = 0;
    int   miscompares = 0;
    int   protoViol = 0;
    rec_t capt[$];
    int   delayLog[$];
    cmd_t batch[$];
    logic directed;
    int   directedDelay;
    logic clrAtSet;
    logic clrPulse;
    logic clrReq;

    assign err_clr = clrPulse | clrReq;

    psg_bus_writer #(
        .STROBE_CYC  (STROBE),
        .TIMEOUT_CYC (TIMEOUT),
        .GAP_CYC     (GAP)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_channel (cmd_channel),
        .cmd_is_vol  (cmd_is_vol),
        .cmd_value   (cmd_value),
        .READY       (READY),
        .nCE         (nCE),
        .nWE         (nWE),
        .D           (D),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: byte values from plain arithmetic, nWE low time from READY delay.
    function automatic void encode(input cmd_t c, output int n, output logic [7:0] b0, output logic [7:0] b1);
        int v;
        int ch;
        v  = int'(c.value);
        ch = int'(c.ch);
        b1 = 8'h00;
        if (c.isVol) begin
            n  = 1;
            b0 = 8'(128 + ch * 32 + 16 + v % 16);
        end else if (ch == 3) begin
            n  = 1;
            b0 = 8'(128 + 96 + v % 8);
        end else begin
            n  = 2;
            b0 = 8'(128 + ch * 32 + v % 16);
            b1 = 8'(v / 16);
        end
    endfunction

    function automatic int expLowFor(input int d);
        int w;
        w = d - STROBE;
        if (w < 1) w = 1;
        if (w > TIMEOUT) w = TIMEOUT;
        return STROBE + w;
    endfunction

    function automatic logic timesOut(input int d);
        return (d - STROBE) > TIMEOUT;
    endfunction

    function automatic int pickDelay();
        if ($urandom_range(0, 7) == 0) return 300;
        return int'($urandom_range(0, 24));
    endfunction

    function automatic vec_t mkVec(input int ch, input int isVol, input int value, input int delay,
                                   input int clr, input int n, input int b0, input int b1,
                                   input int low, input int err);
        vec_t v;
        v.cmd.ch      = 2'(ch);
        v.cmd.isVol   = 1'(isVol);
        v.cmd.value   = 10'(value);
        v.readyDelay  = delay;
        v.clrAtSet    = 1'(clr);
        v.nBytes      = n;
        v.b0          = 8'(b0);
        v.b1          = 8'(b1);
        v.expLow      = low;
        v.expErr      = 1'(err);
        return v;
    endfunction

    // READY responder: READY rises once nWE has been low for the chosen number of cycles.
    initial begin : readyDriver
        int lowRun;
        int curDelay;
        lowRun   = 0;
        curDelay = 0;
        READY    = 1'b0;
        clrPulse = 1'b0;
        forever begin
            @(negedge CLK);
            clrPulse = 1'b0;
            if (nWE === 1'b0) begin
                if (lowRun == 0) begin
                    curDelay = directed ? directedDelay : pickDelay();
                    delayLog.push_back(curDelay);
                end
                lowRun++;
                READY = (lowRun >= curDelay);
                if (clrAtSet && lowRun == STROBE + TIMEOUT) clrPulse = 1'b1;
            end else begin
                lowRun = 0;
                READY  = 1'b0;
            end
        end
    end

    // Bus monitor: captures each strobed byte and counts protocol violations.
    initial begin : busMonitor
        logic       inLow;
        logic [7:0] startD;
        int         lowCnt;
        int         setupCnt;
        inLow    = 1'b0;
        startD   = 8'h00;
        lowCnt   = 0;
        setupCnt = 0;
        forever begin
            @(negedge CLK);
            if (busy === 1'b0 && D !== 8'h00) begin
                protoViol++;
                $display("[TB] protocol: D=%h while idle", D);
            end
            if (nWE === 1'b0) begin
                if (nCE !== 1'b0) begin
                    protoViol++;
                    $display("[TB] protocol: nWE low with nCE high");
                end
                if (!inLow) begin
                    if (setupCnt != 1) begin
                        protoViol++;
                        $display("[TB] protocol: setup lasted %0d cycles", setupCnt);
                    end
                    inLow  = 1'b1;
                    lowCnt = 0;
                    startD = D;
                end else if (D !== startD) begin
                    protoViol++;
                    $display("[TB] protocol: D moved %h -> %h under nWE low", startD, D);
                end
                lowCnt++;
            end else begin
                if (inLow) begin
                    capt.push_back('{d: startD, low: lowCnt});
                    if (nRST === 1'b1 && (nCE !== 1'b0 || D !== startD)) begin
                        protoViol++;
                        $display("[TB] protocol: bad release nCE=%b D=%h", nCE, D);
                    end
                    inLow    = 1'b0;
                    setupCnt = 0;
                end else if (nCE === 1'b0) begin
                    setupCnt++;
                end else begin
                    setupCnt = 0;
                end
            end
        end
    end

    task automatic pushBatch(input int gapMax, output int stallAt);
        int   k;
        int   guard;
        logic rdy;
        k       = 0;
        guard   = 0;
        stallAt = -1;
        while (k < batch.size() && guard < 30000) begin
            cmd_valid   = 1'b1;
            cmd_channel = batch[k].ch;
            cmd_is_vol  = batch[k].isVol;
            cmd_value   = batch[k].value;
            rdy         = cmd_ready;
            if (!rdy && stallAt < 0) stallAt = k;
            @(negedge CLK);
            guard++;
            if (rdy) begin
                k++;
                if (gapMax > 0) begin
                    cmd_valid = 1'b0;
                    repeat ($urandom_range(0, gapMax)) @(negedge CLK);
                end
            end
        end
        cmd_valid = 1'b0;
        if (k < batch.size()) check("push_timeout", k, batch.size());
    endtask

    task automatic waitIdle(input int limit);
        int n;
        n = 0;
        @(negedge CLK);
        while (busy !== 1'b0 && n < limit) begin
            @(negedge CLK);
            n++;
        end
        if (busy !== 1'b0) check("idle_timeout", busy, 0);
    endtask

    task automatic clearErr();
        clrReq = 1'b1;
        @(negedge CLK);
        clrReq = 1'b0;
        check("err_clr", err_timeout, 0);
    endtask

    task automatic modelCheck(input string tag, input int captBase, input int logBase);
        int         ci;
        int         li;
        int         n;
        int         d;
        logic [7:0] b0;
        logic [7:0] b1;
        logic       expErr;
        logic       stop;
        ci     = captBase;
        li     = logBase;
        expErr = 1'b0;
        stop   = 1'b0;
        for (int k = 0; k < batch.size() && !stop; k++) begin
            encode(batch[k], n, b0, b1);
            for (int i = 0; i < n; i++) begin
                if (ci >= capt.size() || li >= delayLog.size()) begin
                    check($sformatf("%s_missing_byte", tag), ci - captBase, capt.size() - captBase + 1);
                    stop = 1'b1;
                    break;
                end
                d = delayLog[li];
                check($sformatf("%s_cmd%0d_byte%0d", tag, k, i), capt[ci].d, (i == 0) ? b0 : b1);
                check($sformatf("%s_cmd%0d_low%0d", tag, k, i), capt[ci].low, expLowFor(d));
                ci++;
                li++;
                if (timesOut(d)) begin
                    expErr = 1'b1;
                    break;
                end
            end
        end
        check($sformatf("%s_byte_count", tag), capt.size() - captBase, ci - captBase);
        check($sformatf("%s_err", tag), err_timeout, expErr);
        check($sformatf("%s_protocol", tag), protoViol, 0);
    endtask

    task automatic applyStimulus(input vec_t v);
        int stall;
        directed      = 1'b1;
        directedDelay = v.readyDelay;
        clrAtSet      = v.clrAtSet;
        batch.delete();
        batch.push_back(v.cmd);
        pushBatch(0, stall);
        waitIdle(2000);
        clrAtSet = 1'b0;
    endtask

    task automatic checkOutput(input int idx, input vec_t v, input int base);
        check($sformatf("vec%0d_byte_count", idx), capt.size() - base, v.nBytes);
        for (int i = 0; i < v.nBytes && base + i < capt.size(); i++) begin
            check($sformatf("vec%0d_D%0d", idx, i), capt[base + i].d, (i == 0) ? v.b0 : v.b1);
            check($sformatf("vec%0d_low%0d", idx, i), capt[base + i].low, v.expLow);
        end
        check($sformatf("vec%0d_err", idx), err_timeout, v.expErr);
        check($sformatf("vec%0d_protocol", idx), protoViol, 0);
        clearErr();
    endtask

    initial begin : mainSeq
        vec_t vecs[10];
        int   base;
        int   logBase;
        int   stallAt;
        int   n;
        cmd_t c;

        nRST          = 1'b0;
        cmd_valid     = 1'b0;
        cmd_channel   = 2'd0;
        cmd_is_vol    = 1'b0;
        cmd_value     = 10'd0;
        clrReq        = 1'b0;
        directed      = 1'b1;
        directedDelay = 0;
        clrAtSet      = 1'b0;

        //              ch vol value  delay  clr n  b0     b1     low  err
        vecs[0] = mkVec(1, 0, 'h2A5, 3,     0,  2, 'hA5, 'h2A, 17,  0);
        vecs[1] = mkVec(2, 1, 'h007, 3,     0,  1, 'hD7, 'h00, 17,  0);
        vecs[2] = mkVec(3, 0, 'h005, 3,     0,  1, 'hE5, 'h00, 17,  0);
        vecs[3] = mkVec(0, 0, 'h3FF, NEVER, 0,  1, 'h8F, 'h00, 271, 1);
        vecs[4] = mkVec(2, 1, 'h3F7, 0,     0,  1, 'hD7, 'h00, 17,  0);
        vecs[5] = mkVec(3, 0, 'h3FD, 0,     0,  1, 'hE5, 'h00, 17,  0);
        vecs[6] = mkVec(0, 0, 'h001, 40,    0,  2, 'h81, 'h00, 40,  0);
        vecs[7] = mkVec(2, 0, 'h3F0, 271,   0,  2, 'hC0, 'h3F, 271, 0);
        vecs[8] = mkVec(1, 0, 'h155, 272,   1,  1, 'hA5, 'h00, 271, 1);
        vecs[9] = mkVec(3, 1, 'h00A, 18,    0,  1, 'hFA, 'h00, 18,  0);

        #12;
        check("reset_nCE", nCE, 1);
        check("reset_nWE", nWE, 1);
        check("reset_D", D, 0);
        check("reset_busy", busy, 0);
        check("reset_err", err_timeout, 0);
        check("reset_cmd_ready", cmd_ready, 1);
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 10; i++) begin
            base = capt.size();
            applyStimulus(vecs[i]);
            checkOutput(i, vecs[i], base);
        end

        directed = 1'b0;
        batch.delete();
        for (int i = 0; i < 6; i++) begin
            c.ch    = 2'($urandom_range(0, 3));
            c.isVol = 1'($urandom_range(0, 1));
            c.value = 10'($urandom);
            batch.push_back(c);
        end
        base    = capt.size();
        logBase = delayLog.size();
        pushBatch(0, stallAt);
        check("backpressure_stall_index", stallAt, 5);
        waitIdle(20000);
        modelCheck("bp", base, logBase);
        clearErr();

        for (int r = 0; r < 3; r++) begin
            batch.delete();
            for (int i = 0; i < 8; i++) begin
                c.ch    = 2'($urandom_range(0, 3));
                c.isVol = 1'($urandom_range(0, 1));
                c.value = 10'($urandom);
                batch.push_back(c);
            end
            base    = capt.size();
            logBase = delayLog.size();
            pushBatch(3, stallAt);
            waitIdle(20000);
            modelCheck($sformatf("rnd%0d", r), base, logBase);
            clearErr();
        end

        // Reset in the middle of a tone latch strobe.
        directed      = 1'b1;
        directedDelay = 3;
        batch.delete();
        c.ch    = 2'd1;
        c.isVol = 1'b0;
        c.value = 10'h2A5;
        batch.push_back(c);
        base = capt.size();
        pushBatch(0, stallAt);
        n = 0;
        while (nWE !== 1'b0 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (nWE !== 1'b0) check("rst_strobe_timeout", nWE, 0);
        repeat (4) @(negedge CLK);
        @(posedge CLK);
        #2 nRST = 1'b0;
        #1;
        check("rst_mid_nWE", nWE, 1);
        check("rst_mid_nCE", nCE, 1);
        check("rst_mid_D", D, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_cmd_ready", cmd_ready, 1);
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        repeat (60) @(negedge CLK);
        check("rst_byte_count", capt.size() - base, 1);
        if (capt.size() > base) check("rst_aborted_D", capt[base].d, 8'hA5);
        check("rst_busy_after", busy, 0);

        batch.delete();
        c.ch    = 2'd0;
        c.isVol = 1'b1;
        c.value = 10'h003;
        batch.push_back(c);
        base = capt.size();
        pushBatch(0, stallAt);
        waitIdle(2000);
        check("post_rst_byte_count", capt.size() - base, 1);
        if (capt.size() > base) begin
            check("post_rst_D", capt[base].d, 8'h93);
            check("post_rst_low", capt[base].low, 17);
        end
        check("post_rst_protocol", protoViol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
